sum_sq_feed: RTL and testbench

- Upstream feeder for the integer square-root stage in the Pythagorean-theorem datapath.
- Accepts two unsigned legs a and b and computes rad = a*a + b*b with a sequential shift-add multiplier.
- Presents rad to the sqrt stage and issues its one-cycle start pulse.
- Obeys the sqrt stage's busy signal so no operation is dropped.

---
 rtl/sum_sq_feed.sv | 147 ++++++++++++++
 tb/tb_sum_sq_feed.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/sum_sq_feed.sv
// Computes rad = a*a + b*b and hands it to the integer sqrt stage with a guarded start pulse.
// Build option: define SUM_SQ_FAST_MUL_EN for single-cycle squaring (default: sequential shift-add).
module sum_sq_feed #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 2*IN_W+2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  a,
  input  logic [IN_W-1:0]  b,
  output logic             sq_start,
  input  logic             sq_busy,
  output logic [OUT_W-1:0] rad,
  output logic             busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SQ_A = 2'd1;
  localparam logic [1:0] ST_SQ_B = 2'd2;
  localparam logic [1:0] ST_SEND = 2'd3;

  logic [1:0]       state_reg, state_next;
  logic [IN_W-1:0]  b_reg;
  logic [OUT_W-1:0] acc_reg;
  logic [OUT_W-1:0] acc_next;
  logic [OUT_W-1:0] rad_reg;
  logic             sq_start_reg;
  logic             phase_done;
  logic             fire;

`ifdef SUM_SQ_FAST_MUL_EN
  logic [IN_W-1:0]  a_reg;
  logic [OUT_W-1:0] a_ext, b_ext;

  assign a_ext      = OUT_W'(a_reg);
  assign b_ext      = OUT_W'(b_reg);
  assign phase_done = 1'b1;
  // SQ_A overwrites the accumulator with a*a; SQ_B adds b*b on top.
  assign acc_next   = (state_reg == ST_SQ_A) ? (a_ext * a_ext) : (acc_reg + b_ext * b_ext);

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg <= '0;
    end else if (state_reg == ST_IDLE && in_valid) begin
      a_reg <= a;
    end
  end
`else
  localparam int CNT_W = $clog2(IN_W + 1);

  logic [OUT_W-1:0] mcand_reg;
  logic [IN_W-1:0]  mplier_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [OUT_W-1:0] addend;

  // Partial product for this step: multiplicand gated by the current multiplier LSB.
  generate
    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_addend
      assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
    end
  endgenerate

  assign phase_done = (cnt_reg == CNT_W'(IN_W - 1));
  assign acc_next   = acc_reg + addend;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            mcand_reg  <= OUT_W'(a);
            mplier_reg <= a;
            cnt_reg    <= '0;
          end
        end
        ST_SQ_A, ST_SQ_B: begin
          if (phase_done && state_reg == ST_SQ_A) begin
            // Second square starts from the latched b; accumulator keeps a*a.
            mcand_reg  <= OUT_W'(b_reg);
            mplier_reg <= b_reg;
            cnt_reg    <= '0;
          end else begin
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
`endif

  // Hold off while the sqrt stage is busy or right after our own pulse (its busy lags by a cycle).
  assign fire = (state_reg == ST_SEND) && !sq_busy && !sq_start_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (in_valid)   state_next = ST_SQ_A;
      ST_SQ_A: if (phase_done) state_next = ST_SQ_B;
      ST_SQ_B: if (phase_done) state_next = ST_SEND;
      ST_SEND: if (fire)       state_next = ST_IDLE;
      default:                 state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      b_reg        <= '0;
      acc_reg      <= '0;
      rad_reg      <= '0;
      sq_start_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      sq_start_reg <= fire;
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            b_reg   <= b;
            acc_reg <= '0;
          end
        end
        ST_SQ_A: acc_reg <= acc_next;
        ST_SQ_B: begin
          acc_reg <= acc_next;
          // rad only changes when a new sum is complete, so it stays put through SEND and after.
          if (phase_done) rad_reg <= acc_next;
        end
        default: ;
      endcase
    end
  end

  assign in_ready = (state_reg == ST_IDLE);
  assign busy     = (state_reg != ST_IDLE);
  assign sq_start = sq_start_reg;
  assign rad      = rad_reg;

endmodule

// File: tb/tb_sum_sq_feed.sv
// Scoreboard bench for sum_sq_feed: driver queues expected (rad, start cycle); monitor checks each sq_start.
module tb_sum_sq_feed;

  localparam int IN_W  = 3;
  localparam int OUT_W = 2*IN_W+2;
`ifdef SUM_SQ_FAST_MUL_EN
  localparam int LAT    = 3;
  localparam int RST_AT = 2;
`else
  localparam int LAT    = 7;
  localparam int RST_AT = 4;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  a, b;
  logic             sq_start;
  logic             sq_busy;
  logic [OUT_W-1:0] rad;
  logic             busy;

  sum_sq_feed #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sq_start(sq_start), .sq_busy(sq_busy), .rad(rad), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int rad; int cyc; } exp_t;
  exp_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every sq_start must match the oldest queued expectation.
  initial begin : monitor
    bit   prev_start;
    exp_t e;
    prev_start = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (sq_start === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_sq_start", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rad", int'(rad), e.rad);
          chk("start_cycle", cyc, e.cyc);
        end
        if (prev_start) chk("consecutive_start", 1, 0);
      end
      prev_start = (sq_start === 1'b1);
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a pair, wait for acceptance, optionally queue the expected result.
  task automatic do_pair(input logic [IN_W-1:0] pa, input logic [IN_W-1:0] pb,
                         input int er, input int lat, input bit hold, input bit push,
                         output int t);
    int guard;
    a = pa; b = pb; in_valid = 1'b1;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 100) begin
      wait_cyc(1);
      guard++;
    end
    if (guard >= 100) chk("accept_timeout", 0, 1);
    wait_cyc(1);
    t = cyc;
    $display("[TB] pair a=%0d b=%0d accepted at cycle %0d", pa, pb, t);
    if (!hold) in_valid = 1'b0;
    if (push) exp_q.push_back('{er, t + lat});
  endtask

  initial begin : driver
    int t, t1, t2, guard;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sq_busy = 1'b0;
    wait_cyc(2);
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_sq_start", int'(sq_start), 0);
    chk("reset_rad", int'(rad), 0);
    rst = 1'b0;

    // 3,4 -> 25 with latency and in_ready timing
    do_pair(3'd3, 3'd4, 25, LAT, 1'b0, 1'b1, t);
    wait_cyc(LAT - 1);
    chk("in_ready_before_send_done", int'(in_ready), 0);
    wait_cyc(2);
    chk("in_ready_after_start", int'(in_ready), 1);
    wait_cyc(2);

    do_pair(3'd7, 3'd7, 98, LAT, 1'b0, 1'b1, t);
    wait_cyc(LAT + 3);
    do_pair(3'd0, 3'd0, 0, LAT, 1'b0, 1'b1, t);
    wait_cyc(LAT + 3);

    // Sqrt stage busy from T to T+12: start delayed to T+13
    sq_busy = 1'b1;
    do_pair(3'd5, 3'd2, 29, 13, 1'b0, 1'b1, t);
    wait_cyc(10);
    chk("stall_in_ready", int'(in_ready), 0);
    chk("stall_rad", int'(rad), 29);
    chk("stall_busy", int'(busy), 1);
    wait_cyc(2);
    sq_busy = 1'b0;
    wait_cyc(4);

    // Back-to-back with in_valid held
    do_pair(3'd1, 3'd1, 2, LAT, 1'b1, 1'b1, t1);
    do_pair(3'd2, 3'd3, 13, LAT, 1'b0, 1'b1, t2);
    chk("b2b_accept_gap", t2 - t1, LAT + 1);
    wait_cyc(LAT + 3);

    // Reset mid-operation aborts: no start pulse for (6,6)
    do_pair(3'd6, 3'd6, 0, 0, 1'b0, 1'b0, t);
    wait_cyc(RST_AT);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    chk("abort_in_ready", int'(in_ready), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_sq_start", int'(sq_start), 0);
    chk("abort_rad", int'(rad), 0);
    wait_cyc(10);
    do_pair(3'd1, 3'd2, 5, LAT, 1'b0, 1'b1, t);

    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      wait_cyc(1);
      guard++;
    end
    chk("pending_expectations", exp_q.size(), 0);
    wait_cyc(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
